// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and FSM state type for seq_magnitude_multiplier
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  function automatic int mult_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MULT_CNT_W = mult_cnt_w(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mult_state_e;

endpackage

// File: rtl/seq_magnitude_multiplier.sv
// rtl/seq_magnitude_multiplier.sv - shift-add magnitude multiplier with sign fix-up stage
// Optional MULT_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are zero.
module seq_magnitude_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand_abs,
  input  logic [WIDTH-1:0]   mplier_abs,
  input  logic               sign_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = mult_cnt_w(WIDTH);

  mult_state_e        state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               done_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] product_d;
  logic               last_iter_d;

  always_comb begin
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product_d = sign_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
`ifdef MULT_EARLY_EXIT_EN
    // The multiplier after this iteration's shift is just its upper bits.
    last_iter_d = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_abs};
            mplier_q <= mplier_abs;
            sign_q   <= sign_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          product_q <= product_d;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_magnitude_multiplier.sv
// tb/tb_seq_magnitude_multiplier.sv - scoreboard bench for seq_magnitude_multiplier (MULT_EARLY_EXIT_EN aware)
module tb_seq_magnitude_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   mcand_abs;
  logic [W-1:0]   mplier_abs;
  logic           sign_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  seq_magnitude_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mcand_abs (mcand_abs),
    .mplier_abs(mplier_abs),
    .sign_in   (sign_in),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             edge_n;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             next_free = 0;
  int             last_e = 0;
  logic [2*W-1:0] hold_val = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input int a, input int b, input bit s);
    int m;
    m = a * b;
    if (s) m = -m;
    return m[2*W-1:0];
  endfunction

  // Edges from the sampling start edge (counted as 1) through the edge that raises done.
  function automatic int ref_lat(input int b);
    int hb;
    hb = 0;
`ifdef MULT_EARLY_EXIT_EN
    for (int i = 0; i < W; i++) if ((b >> i) & 1) hb = i;
    return hb + 1 + 2;
`else
    hb = W;
    return hb + 2;
`endif
  endfunction

  task automatic issue_now(input bit st, input int a, input int b, input bit s);
    int e;
    start      = st;
    mcand_abs  = a[W-1:0];
    mplier_abs = b[W-1:0];
    sign_in    = s;
    e = cyc + 1;
    if (st && rst_n && e >= next_free) begin
      sb.push_back('{prod: ref_prod(a, b, s), edge_n: e + ref_lat(b) - 1});
      next_free = e + ref_lat(b) + 1;
      last_e = e;
    end
  endtask

  task automatic drive(input bit st, input int a, input int b, input bit s);
    @(posedge clk);
    #1;
    issue_now(st, a, b, s);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && (cyc + 1 < next_free); k++) drive(0, 0, 0, 0);
  endtask

  // Monitor: every done pops one expected result; product must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("product", 32'(product), 32'(x.prod));
          chk("done_edge", 32'(cyc), 32'(x.edge_n));
          hold_val = x.prod;
        end
      end else if (product !== hold_val) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL product_hold: got 0x%0h expected 0x%0h (cycle %0d)", product, hold_val, cyc);
      end
    end
  end

  initial begin
    int busy_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    mcand_abs = '0;
    mplier_abs = '0;
    sign_in = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 5*3 with busy window check
    drive(1, 5, 3, 0);
    drive(0, 0, 0, 0);
    busy_cnt = 0;
    for (int k = 0; k < ref_lat(3) - 1; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(ref_lat(3) - 1));
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    wait_idle();

    // Extremes and zero magnitude
    drive(1, 128, 128, 0); drive(0, 0, 0, 0); wait_idle();
    drive(1, 128, 127, 1); drive(0, 0, 0, 0); wait_idle();
    drive(1, 0, 200, 1);   drive(0, 0, 0, 0); wait_idle();
    // Early-exit shapes (full length without the macro)
    drive(1, 3, 1, 1);     drive(0, 0, 0, 0); wait_idle();
    drive(1, 9, 8'h80, 0); drive(0, 0, 0, 0); wait_idle();

    // start held with inputs changing every cycle
    for (int k = 0; k < 30; k++) drive(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    drive(0, 0, 0, 0);
    wait_idle();

    // Reset during the 4th RUN cycle aborts without done
    drive(1, 100, 8'hF1, 1);
    drive(0, 0, 0, 0);
    while (cyc < last_e + 3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    next_free = 0;
    hold_val = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue_now(1, 7, 9, 0);
    drive(0, 0, 0, 0);
    wait_idle();

    // Random single-pulse operations with random gaps
    for (int k = 0; k < 40; k++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
      repeat ($urandom_range(0, 14)) drive(0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
    end
    drive(0, 0, 0, 0);

    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_multiplier.md
SEQ_MAGNITUDE_MULTIPLIER -- requirements
Module: seq_magnitude_multiplier

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: magnitude operand width; product width is 2*WIDTH.
REQ-002 The module SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The module SHALL have port mcand_abs, input, WIDTH bits: unsigned multiplicand magnitude, output of the upstream sign/abs stage.
REQ-006 The module SHALL have port mplier_abs, input, WIDTH bits: unsigned multiplier magnitude, output of the upstream sign/abs stage.
REQ-007 The module SHALL have port sign_in, input, 1 bit: result sign from the upstream stage, where 1 means negative.
REQ-008 The module SHALL have port busy, output, 1 bit: high in RUN and SIGN.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse indicating product valid.
REQ-010 The module SHALL have port product, output, 2*WIDTH bits: signed two's-complement result, held until overwritten.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, RUN, SIGN and DONE.
REQ-012 In IDLE, when start=1 at an edge, the block SHALL capture mcand_abs zero-extended to 2*WIDTH, mplier_abs, and sign_in, clear the accumulator and the iteration counter, and enter RUN.
REQ-013 In IDLE, when start=0, the block SHALL remain in IDLE.
REQ-014 At each RUN edge, the block SHALL add the shifted multiplicand to the accumulator if mplier[0]=1, shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-015 RUN SHALL exit to SIGN on the edge that completes iteration WIDTH (counter reaches WIDTH-1 before incrementing).
REQ-016 The SIGN state SHALL last one cycle, set product to (sign_latched ? two's-complement negation of acc : acc), and transition to DONE.
REQ-017 The DONE state SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-018 With WIDTH=8 and the macro undefined, done SHALL go high 10 edges after the edge that sampled start (8 RUN + SIGN + DONE entry).
REQ-019 start SHALL be ignored in RUN, SIGN, and DONE; it SHALL NOT restart or queue an operation.
REQ-020 Inputs SHALL be read only on the start edge; input changes during busy SHALL NOT affect the result.
REQ-021 A zero magnitude product SHALL yield product=0 regardless of sign_in.
REQ-022 The extremes (-128*-128 = 16384 = 0x4000 and -128*127 = -16256 = 0xC080) SHALL be represented exactly, with no overflow.
REQ-023 product SHALL change only in SIGN and SHALL hold its value through IDLE and later operations until the next SIGN.

Reset
REQ-024 When rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, product=0, and clear the accumulator, counter, and latched operands.
REQ-025 A reset asserted mid-RUN or mid-SIGN SHALL abort the operation and produce no done pulse.
REQ-026 After reset release, the first start SHALL be honoured on the first rising edge with rst_n=1.

Configuration
REQ-027 When MULT_EARLY_EXIT_EN is defined, RUN SHALL also exit to SIGN after any iteration whose post-shift multiplier is zero.
REQ-028 With MULT_EARLY_EXIT_EN defined, latency SHALL equal (index of highest set bit of mplier_abs, or 0 if mplier_abs is zero) + 1 RUN cycles, plus SIGN and DONE.
REQ-029 When MULT_EARLY_EXIT_EN is undefined, the block SHALL always perform exactly WIDTH RUN cycles.
REQ-030 The product value SHALL be identical in both builds.

Structure
REQ-031 The shared package mult_pkg SHALL hold the FSM state enum typedef, the default WIDTH constant, and the counter-width constant $clog2(WIDTH).
REQ-032 The block SHALL have no sub-modules; negation SHALL be done inline in SIGN.

Verification
REQ-033 The bench SHALL cover: mcand=5, mplier=3, sign=0, start pulse -> done after 10 edges, product=0x000F, busy high during 9 preceding cycles.
REQ-034 The bench SHALL cover: mcand=128, mplier=128, sign=0 (i.e. -128*-128) -> product=0x4000; mcand=128, mplier=127, sign=1 -> product=0xC080.
REQ-035 The bench SHALL cover: mcand=0, mplier=200, sign=1 -> product=0x0000, a single done pulse, and done low at all other times.
REQ-036 The bench SHALL cover: start held high for 30 cycles with inputs changing -> exactly one result per IDLE visit, and each result matches the inputs on its start edge.
REQ-037 The bench SHALL cover: rst_n pulsed low on the 4th RUN cycle -> busy=0, product=0, no done; the next start computes 7*9=0x003F correctly.
REQ-038 The bench SHALL cover, with MULT_EARLY_EXIT_EN defined: mplier=1 -> 1 RUN cycle and done 3 edges after start; mplier=0x80 -> 8 RUN cycles; both products correct.
